adc_sched: RTL and testbench

//  Run-control scheduler for the 8-channel ADC capture path. Decodes 2-byte host commands arriving

---
 rtl/adc_pkg.sv | 34 +++
 rtl/adc_sched_cmd.sv | 62 ++++++
 rtl/adc_sched.sv | 176 +++++++++++++++++
 tb/tb_adc_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants for the ADC run-control scheduler: opcodes, FSM states, reset values.
package adc_pkg;

    localparam int CLK_FREQ      = 36_000_000;
    localparam int DEFAULT_RATE  = 48_000;
    localparam int DEFAULT_FLUSH = 48;
    localparam int DIV_WIDTH     = 16;
    localparam int FLUSH_WIDTH   = 8;

    localparam logic [DIV_WIDTH-1:0]   DIV_RESET   = DIV_WIDTH'(CLK_FREQ / DEFAULT_RATE - 1);
    localparam logic [DIV_WIDTH-1:0]   DIV_MIN     = DIV_WIDTH'(63);
    localparam logic [FLUSH_WIDTH-1:0] FLUSH_RESET = FLUSH_WIDTH'(DEFAULT_FLUSH - 1);

    localparam logic [7:0] OP_START     = 8'h01;
    localparam logic [7:0] OP_STOP      = 8'h02;
    localparam logic [7:0] OP_SET_MASK  = 8'h10;
    localparam logic [7:0] OP_DIV_HI    = 8'h11;
    localparam logic [7:0] OP_DIV_LO    = 8'h12;
    localparam logic [7:0] OP_SET_FLUSH = 8'h13;
    localparam logic [7:0] OP_CLR_ERR   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/adc_sched_cmd.sv
// Host command byte framing: opcode/argument phase, opcode capture and DIV_HI shadow.
// Emits a one-cycle strobe in the argument-byte cycle; legality is decided by the parent.
module adc_sched_cmd
    import adc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_sync_i,
    input  logic       cfg_ok_i,
    output logic       cmd_stb_o,
    output logic [7:0] cmd_op_o,
    output logic [7:0] cmd_arg_o,
    output logic [7:0] div_hi_o
);

    logic       arg_phase_q, arg_phase_d;
    logic [7:0] op_q, op_d;
    logic [7:0] hi_q, hi_d;
    logic       stb;

    // A sync coinciding with a byte makes that byte an opcode.
    always_comb begin
        arg_phase_d = arg_phase_q;
        op_d        = op_q;
        hi_d        = hi_q;
        stb         = 1'b0;
        if (cmd_valid_i) begin
            if (cmd_sync_i || !arg_phase_q) begin
                op_d        = cmd_data_i;
                arg_phase_d = 1'b1;
            end else begin
                stb         = 1'b1;
                arg_phase_d = 1'b0;
            end
        end else if (cmd_sync_i) begin
            arg_phase_d = 1'b0;
        end
        if (stb && (op_q == OP_DIV_HI) && cfg_ok_i) begin
            hi_d = cmd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            arg_phase_q <= 1'b0;
            op_q        <= 8'h00;
            hi_q        <= 8'h00;
        end else begin
            arg_phase_q <= arg_phase_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
        end
    end

    assign cmd_stb_o = stb;
    assign cmd_op_o  = op_q;
    assign cmd_arg_o = cmd_data_i;
    assign div_hi_o  = hi_q;

endmodule

// File: rtl/adc_sched.sv
// ADC run-control scheduler: conversion pacing, frame resync, stop-on-frame and overflow fault.
// Optional conversion watchdog is compiled in with ADC_SCHED_WATCHDOG_EN.
//
//  state | meaning
//  IDLE  | stopped, configuration writes allowed
//  ARM   | one cycle, clears divider and sample counters
//  RUN   | converting, framing samples
//  DRAIN | stop requested, finishing the current frame
//  FAULT | overflow/watchdog, waits for CLR_ERR
module adc_sched
    import adc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       cmd_sync,
    input  logic       sample_valid,
    input  logic       fifo_error,
    output logic       conv_start,
    output logic       resync,
    output logic [7:0] chan_mask,
    output logic       running,
    output logic       fault,
    output logic       cmd_reject
);

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d, div_ctr_q, div_ctr_d;
    logic [FLUSH_WIDTH-1:0] flush_q, flush_d, smp_ctr_q, smp_ctr_d, smp_next;
    logic [7:0]             mask_q, mask_d;
    logic                   resync_q, resync_d, reject_q, reject_d;
    logic                   cmd_stb;
    logic [7:0]             cmd_op, cmd_arg, div_hi;
    logic                   active, smp_hit, wd_fire, halt;

    adc_sched_cmd u_cmd (
        .clk_i       (clk),
        .rst_ni      (rst),
        .cmd_data_i  (cmd_data),
        .cmd_valid_i (cmd_valid),
        .cmd_sync_i  (cmd_sync),
        .cfg_ok_i    (state_q == ST_IDLE),
        .cmd_stb_o   (cmd_stb),
        .cmd_op_o    (cmd_op),
        .cmd_arg_o   (cmd_arg),
        .div_hi_o    (div_hi)
    );

    assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign conv_start = active && (div_ctr_q == '0);
    assign smp_hit    = sample_valid && (smp_ctr_q == flush_q);
    assign smp_next   = smp_hit ? '0 : smp_ctr_q + FLUSH_WIDTH'(sample_valid);

`ifdef ADC_SCHED_WATCHDOG_EN
    logic [DIV_WIDTH:0] wd_ctr_q, wd_ctr_d;
    logic               wd_arm_q, wd_arm_d;

    // Armed by the oldest unanswered conv_start; later conversions do not extend the window.
    always_comb begin
        wd_arm_d = wd_arm_q;
        wd_ctr_d = wd_ctr_q;
        if (!active) begin
            wd_arm_d = 1'b0;
            wd_ctr_d = '0;
        end else if (conv_start && (!wd_arm_q || sample_valid)) begin
            wd_arm_d = 1'b1;
            wd_ctr_d = {div_q, 1'b0};
        end else if (sample_valid) begin
            wd_arm_d = 1'b0;
        end else if (wd_arm_q && (wd_ctr_q != '0)) begin
            wd_ctr_d = wd_ctr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_arm_q <= 1'b0;
            wd_ctr_q <= '0;
        end else begin
            wd_arm_q <= wd_arm_d;
            wd_ctr_q <= wd_ctr_d;
        end
    end

    assign wd_fire = wd_arm_q && (wd_ctr_q == '0) && !sample_valid;
`else
    assign wd_fire = 1'b0;
`endif

    assign halt = fifo_error || wd_fire;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        flush_d   = flush_q;
        mask_d    = mask_q;
        div_ctr_d = '0;
        smp_ctr_d = smp_ctr_q;
        resync_d  = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_stb) begin
                    case (cmd_op)
                        OP_START:     state_d = ST_ARM;
                        OP_SET_MASK:  mask_d  = cmd_arg;
                        OP_DIV_LO:    div_d   = clamp_div({div_hi, cmd_arg});
                        OP_SET_FLUSH: flush_d = cmd_arg;
                        OP_STOP, OP_DIV_HI, OP_CLR_ERR: ;
                        default:      reject_d = 1'b1;
                    endcase
                end
            end
            ST_ARM: begin
                smp_ctr_d = '0;
                state_d   = ST_RUN;
                if (cmd_stb) begin
                    if (cmd_op == OP_STOP) state_d  = ST_IDLE;
                    else                   reject_d = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                div_ctr_d = (div_ctr_q == div_q) ? '0 : div_ctr_q + DIV_WIDTH'(1);
                smp_ctr_d = smp_next;
                resync_d  = smp_hit;
                if (cmd_stb && (cmd_op != OP_STOP)) reject_d = 1'b1;
                // A sample in the STOP cycle counts, so a just-completed frame stops cleanly.
                if (halt) begin
                    state_d  = ST_FAULT;
                    resync_d = 1'b1;
                end else if (cmd_stb && (cmd_op == OP_STOP) && (state_q == ST_RUN)) begin
                    state_d = (smp_next == '0) ? ST_IDLE : ST_DRAIN;
                end else if ((state_q == ST_DRAIN) && smp_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (cmd_stb) begin
                    if (cmd_op == OP_CLR_ERR) state_d  = ST_IDLE;
                    else                      reject_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_RESET;
            flush_q   <= FLUSH_RESET;
            mask_q    <= 8'hFF;
            div_ctr_q <= '0;
            smp_ctr_q <= '0;
            resync_q  <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            flush_q   <= flush_d;
            mask_q    <= mask_d;
            div_ctr_q <= div_ctr_d;
            smp_ctr_q <= smp_ctr_d;
            resync_q  <= resync_d;
            reject_q  <= reject_d;
        end
    end

    assign resync     = resync_q;
    assign cmd_reject = reject_q;
    assign chan_mask  = mask_q;
    assign running    = (state_q == ST_ARM) || active;
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_adc_sched.sv
// Scoreboard bench for adc_sched: conv_start timing, resync/reject events, stop/fault/reset behaviour.
module tb_adc_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_sync = 1'b0;
    logic       sample_valid = 1'b0;
    logic       fifo_error = 1'b0;
    logic       conv_start, resync, running, fault, cmd_reject;
    logic [7:0] chan_mask;

    always #5 clk = ~clk;

    adc_sched dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_sync     (cmd_sync),
        .sample_valid (sample_valid),
        .fifo_error   (fifo_error),
        .conv_start   (conv_start),
        .resync       (resync),
        .chan_mask    (chan_mask),
        .running      (running),
        .fault        (fault),
        .cmd_reject   (cmd_reject)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int rs_q[$];
    int rej_q[$];
    int conv_cnt = 0, rs_cnt = 0, tb_smp = 0, tb_frame = 48, period = 750;
    int conv_base = 0, start_id = 0, seen_id = 0, conv_idx = 0, samp_due = -1;
    bit adc_en = 1'b0;
    bit rs_run = 1'b0, rs_prev_run = 1'b0, prev_running = 1'b0;

    task automatic chk_eq(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor plus ADC model: each conv_start yields one sample 3 cycles later.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (conv_start) begin
                if (seen_id != start_id) begin
                    seen_id  = start_id;
                    conv_idx = 0;
                end
                chk_eq("conv_start_cyc", cyc, conv_base + conv_idx * period);
                conv_idx++;
                conv_cnt++;
                if (adc_en) samp_due = cyc + 3;
            end
            if (resync) begin
                rs_cnt++;
                rs_run      = running;
                rs_prev_run = prev_running;
                if (rs_q.size() > 0) chk_eq("resync_cyc", cyc, rs_q.pop_front());
                else                 chk_eq("resync_unexpected", resync, 0);
            end
            if (cmd_reject) begin
                if (rej_q.size() > 0) chk_eq("reject_cyc", cyc, rej_q.pop_front());
                else                  chk_eq("reject_unexpected", cmd_reject, 0);
            end
            prev_running = running;
            if (adc_en && cyc == samp_due) begin
                sample_valid = 1'b1;
                tb_smp++;
                if (tb_smp % tb_frame == 0) rs_q.push_back(cyc + 1);
            end else begin
                sample_valid = 1'b0;
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg, input bit err,
                            input bit sync, output int b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = op; cmd_sync = sync;
        @(posedge clk); #1;
        cmd_sync = 1'b0; cmd_data = arg; fifo_error = err; b1 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; fifo_error = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = v;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_start(output int b1);
        tb_smp   = 0;
        samp_due = -1;
        send_cmd(8'h01, 8'h00, 1'b0, 1'b0, b1);
        conv_base = b1 + 2;
        start_id++;
    endtask

    task automatic wait_rs(input int target, input int budget, input string tag);
        int n = 0;
        while (rs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, rs_cnt, target);
    endtask

    initial begin
        int b, c0, r0, stop_cnt, n, cstart;
        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_running", running, 0);
        chk_eq("rst_fault", fault, 0);
        chk_eq("rst_mask", chan_mask, 8'hFF);
        chk_eq("rst_conv", conv_start, 0);
        chk_eq("rst_resync", resync, 0);
        chk_eq("rst_reject", cmd_reject, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Default rate: START latency, 750-cycle pacing, 48-sample frame
        period = 750; tb_frame = 48; adc_en = 1'b1;
        c0 = conv_cnt;
        do_start(b);
        @(negedge clk);
        chk_eq("running_arm", running, 1);
        @(negedge clk);
        chk_eq("conv_first", conv_start, 1);
        repeat (100) @(posedge clk);
        send_cmd(8'h10, 8'h0F, 1'b0, 1'b0, b);
        rej_q.push_back(b + 1);
        @(negedge clk);
        chk_eq("mask_run_kept", chan_mask, 8'hFF);
        wait_rs(1, 40000, "frame1_resync");
        chk_eq("frame1_convs", conv_cnt - c0, 48);
        chk_eq("frame1_running", running, 1);
        send_cmd(8'h02, 8'h00, 1'b0, 1'b0, b);
        @(negedge clk);
        chk_eq("stop_boundary_idle", running, 0);

        // Configuration in IDLE: divider clamp, mask, unknown opcode
        send_cmd(8'h11, 8'h00, 1'b0, 1'b0, b);
        send_cmd(8'h12, 8'h10, 1'b0, 1'b0, b);
        period = 64;
        send_cmd(8'h10, 8'h0F, 1'b0, 1'b0, b);
        @(negedge clk);
        chk_eq("mask_idle", chan_mask, 8'h0F);
        send_cmd(8'h10, 8'hFF, 1'b0, 1'b0, b);
        send_cmd(8'h55, 8'h00, 1'b0, 1'b0, b);
        rej_q.push_back(b + 1);

        // STOP after sample 20 drains the frame
        c0 = conv_cnt;
        do_start(b);
        n = 0;
        while (tb_smp < 20 && n < 5000) begin @(negedge clk); n++; end
        chk_eq("drain_smp20", tb_smp, 20);
        r0 = rs_cnt;
        stop_cnt = conv_cnt;
        send_cmd(8'h02, 8'h00, 1'b0, 1'b0, b);
        wait_rs(r0 + 1, 5000, "drain_resync");
        chk_eq("drain_convs", conv_cnt - stop_cnt, 28);
        chk_eq("drain_run_at_rs", rs_run, 0);
        chk_eq("drain_run_before_rs", rs_prev_run, 1);

        // cmd_sync realigns a half-received command: flush becomes 3
        send_byte(8'h10);
        send_cmd(8'h13, 8'h03, 1'b0, 1'b1, b);
        @(negedge clk);
        chk_eq("sync_mask_kept", chan_mask, 8'hFF);

        // Short frames, then fifo_error with STOP in the same cycle
        tb_frame = 4;
        r0 = rs_cnt;
        do_start(b);
        wait_rs(r0 + 2, 2000, "short_frames");
        adc_en = 1'b0;
        send_cmd(8'h02, 8'h00, 1'b1, 1'b0, b);
        rs_q.push_back(b + 1);
        @(negedge clk);
        chk_eq("fault_set", fault, 1);
        chk_eq("fault_running", running, 0);
        c0 = conv_cnt;
        r0 = rs_cnt;
        repeat (200) @(posedge clk);
        chk_eq("fault_no_conv", conv_cnt - c0, 0);
        chk_eq("fault_one_resync", rs_cnt - r0, 0);
        send_cmd(8'h01, 8'h00, 1'b0, 1'b0, b);
        rej_q.push_back(b + 1);
        @(negedge clk);
        chk_eq("fault_start_rej", fault, 1);
        send_cmd(8'h20, 8'h00, 1'b0, 1'b0, b);
        @(negedge clk);
        chk_eq("clr_err", fault, 0);
        send_cmd(8'h13, 8'd47, 1'b0, 1'b0, b);
        tb_frame = 48;

        // Missing samples at div 749
        send_cmd(8'h11, 8'h02, 1'b0, 1'b0, b);
        send_cmd(8'h12, 8'hED, 1'b0, 1'b0, b);
        period = 750;
        c0 = conv_cnt;
        do_start(b);
        cstart = b + 2;
`ifdef ADC_SCHED_WATCHDOG_EN
        rs_q.push_back(cstart + 1500);
        n = 0;
        while (!fault && n < 3000) begin @(negedge clk); n++; end
        chk_eq("wd_fault_cyc", cyc, cstart + 1500);
        send_cmd(8'h20, 8'h00, 1'b0, 1'b0, b);
        @(negedge clk);
        chk_eq("wd_clr", fault, 0);
`else
        while (cyc < b + 3100) @(negedge clk);
        chk_eq("nowd_fault", fault, 0);
        chk_eq("nowd_running", running, 1);
        chk_eq("nowd_convs", conv_cnt - c0, 5);
        send_cmd(8'h02, 8'h00, 1'b0, 1'b0, b);
        @(negedge clk);
        chk_eq("nowd_stop", running, 0);
`endif

        // Reset mid-run: no resync, configuration restored
        send_cmd(8'h10, 8'h0F, 1'b0, 1'b0, b);
        adc_en = 1'b1;
        do_start(b);
        repeat (1000) @(posedge clk);
        adc_en = 1'b0;
        c0 = conv_cnt;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_eq("midrst_running", running, 0);
        chk_eq("midrst_mask", chan_mask, 8'hFF);
        chk_eq("midrst_fault", fault, 0);
        repeat (800) @(posedge clk);
        chk_eq("midrst_no_conv", conv_cnt - c0, 0);

        chk_eq("resync_q_left", rs_q.size(), 0);
        chk_eq("reject_q_left", rej_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
